uart_sector_buf: RTL and testbench
==================================

Name: uart_sector_buf

Overview:
- Buffering stage between the UART receiver and the SD write path.
- Collects serial bytes (rx_flag/rx_data) and packs byte pairs into 16-bit words in an internal FIFO.
- Requests an SD single-block write once a full 512-byte sector is buffered, serves words to the SD controller on each wr_en, then advances the sector address.
- Flushes a partial sector, zero-padded, after an idle timeout.

Parameters:
- SECTOR_WORDS, 256: words per SD sector (512 bytes).
- ADDR_W, 9: FIFO address width. Depth is 2^ADDR_W words, i.e. two sectors by default.
- START_ADDR, 32'd2000: sector address of the first write.
- TIMEOUT_CYC, 24'd5_000_000: idle cycles (100 ms at 50 MHz) before a partial flush. 0 disables the timeout.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous reset, active-high (asserted = 1).
- init_end  in  1  SD card initialisation complete.
- rx_flag  in  1  single-cycle strobe: rx_data valid.
- rx_data  in  8  received byte.
- wr_busy  in  1  SD controller write in progress.
- wr_en  in  1  single-cycle strobe: controller consumes wr_data.
- wr_req  out  1  write request to the SD controller.
- wr_addr  out  32  sector address of the current write.
- wr_data  out  16  word presented to the controller.
- sector_done  out  1  single-cycle pulse after each sector completes.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
- fill_level  out  ADDR_W+1  number of words in the FIFO.

Behaviour:
- Reset values:
  - wr_req=0, wr_addr=START_ADDR, wr_data=0, sector_done=0, overflow=0, fill_level=0.
  - Packer half-byte cleared, timeout counter cleared, FSM in IDLE.
  - Reset mid-transfer aborts everything; buffered data is discarded.
- Packing:
  - First byte of a pair goes to [15:8], second byte to [7:0].
  - The word is pushed on the cycle after the second byte's rx_flag.
  - Bytes are accepted regardless of init_end.
- FIFO:
  - Push when full: the word is dropped and overflow is set until reset.
  - Simultaneous push and pop: fill_level is unchanged.
  - Read/write pointers wrap modulo 2^ADDR_W.
- Timeout:
  - The counter resets on every rx_flag.
  - It increments while (fill_level>0 or a half-word is pending) and the FSM is in IDLE.
  - On reaching TIMEOUT_CYC, a pending half-word is pushed with low byte 8'h00, and pad_pend is set.
- FSM states: IDLE, REQ, XFER, WAIT_DONE, DONE.
  - IDLE -> REQ when init_end=1 and (fill_level>=SECTOR_WORDS or pad_pend). On entry, N = min(fill_level, SECTOR_WORDS) is latched.
  - REQ: wr_req=1 is held until wr_busy=1 is sampled, then wr_req=0 -> XFER.
  - XFER:
    - wr_data holds the FIFO head (or 16'h0000 once N words have been popped) before the first wr_en.
    - Each wr_en pops one word (only while fewer than N have been popped) and counts one word.
    - The next wr_data value is valid by the cycle after the wr_en.
    - The controller guarantees at least 2 cycles between wr_en pulses.
    - After SECTOR_WORDS wr_en pulses -> WAIT_DONE.
  - WAIT_DONE: wait for wr_busy=0 -> DONE.
  - DONE:
    - sector_done=1 for one cycle; wr_addr increments by 1 (wraps at 2^32); pad_pend clears; timeout counter clears.
    - -> IDLE.
- wr_en outside XFER is ignored.
- Bytes arriving during a padded transfer are buffered for a later sector and never mixed into the current one; only the N latched words are used.
- init_end low: no request is issued, but buffering continues.

Test Plan:
- Init_end=1; send 512 bytes 0x00..0xFF twice.
  - Expect exactly one wr_req at wr_addr=2000.
  - Words served are 0x0001, 0x0203, ... 0xFEFF, repeated.
  - sector_done pulses once; wr_addr becomes 2001.
- Send 1024 bytes back-to-back while the controller model is slowed.
  - Two sectors are written at 2000 and 2001; overflow=0; fill_level peaks <= 512.
- Send 3 bytes 0xAA,0xBB,0xCC, then idle TIMEOUT_CYC (use 1000 in the bench).
  - Sector served as 0xAABB, 0xCC00, then 254 words of 0x0000.
- During the padded transfer, send 2 more bytes.
  - They do not appear in the current sector; fill_level=1 after DONE.
- Hold init_end=0 and send 1100 bytes.
  - No wr_req; overflow=1 after word 513; fill_level=512.
- Assert sys_rst_n mid-XFER.
  - All outputs return to reset values asynchronously; wr_addr=2000; the next full sector is requested normally.

Source files
------------

// File: rtl/uart_sector_buf.sv
// UART-to-SD sector buffer: packs received bytes into 16-bit words, queues them in a
// block-RAM FIFO and hands 256-word sectors (or a zero-padded partial one) to the SD writer.
`timescale 1ns/1ps
module uart_sector_buf #(
  parameter int unsigned SECTOR_WORDS = 256,
  parameter int unsigned ADDR_W       = 9,
  parameter logic [31:0] START_ADDR   = 32'd2000,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd5_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic              rx_flag,
  input  logic [7:0]        rx_data,
  input  logic              wr_busy,
  input  logic              wr_en,
  output logic              wr_req,
  output logic [31:0]       wr_addr,
  output logic [15:0]       wr_data,
  output logic              sector_done,
  output logic              overflow,
  output logic [ADDR_W:0]   fill_level
);

  localparam int unsigned     CW     = ADDR_W + 1;
  localparam int unsigned     DEPTH  = 1 << ADDR_W;
  localparam logic [CW-1:0]   FULL   = CW'(DEPTH);
  localparam logic [CW-1:0]   SEC    = CW'(SECTOR_WORDS);
  localparam logic [CW-1:0]   SEC_M1 = CW'(SECTOR_WORDS - 1);

  typedef enum logic [2:0] {IDLE, REQ, XFER, WAIT_DONE, DONE} state_t;

  state_t            state_q, state_d;
  logic              half_pend_q, half_pend_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic              push_vld_q, push_vld_d;
  logic [15:0]       push_word_q, push_word_d;
  logic [23:0]       tmo_cnt_q, tmo_cnt_d;
  logic              pad_pend_q, pad_pend_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic              overflow_q, overflow_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     pop_cnt_q, pop_cnt_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic              wr_req_q, wr_req_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic              sector_done_q, sector_done_d;

  logic              flush_fire;
  logic              fifo_push;
  logic [15:0]       fifo_push_word;
  logic              push_ok;
  logic              pop;

  logic [15:0]       mem [0:DEPTH-1];
  logic [15:0]       rd_word_q;

  // Idle flush fires once per padded sector; rx_flag always restarts the idle window.
  always_comb begin
    flush_fire = 1'b0;
    if ((TIMEOUT_CYC != 24'd0) && (state_q == IDLE) && !pad_pend_q && !rx_flag &&
        ((fill_q != '0) || half_pend_q) && (tmo_cnt_q == TIMEOUT_CYC))
      flush_fire = 1'b1;
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (rx_flag || (state_q == DONE))
      tmo_cnt_d = 24'd0;
    else if ((state_q == IDLE) && ((fill_q != '0) || half_pend_q) && (tmo_cnt_q != TIMEOUT_CYC))
      tmo_cnt_d = tmo_cnt_q + 24'd1;
  end

  always_comb begin
    pad_pend_d = pad_pend_q;
    if (state_q == DONE)
      pad_pend_d = 1'b0;
    else if (flush_fire)
      pad_pend_d = 1'b1;
  end

  // Byte packer: the completed word is pushed one cycle after the second byte.
  always_comb begin
    half_pend_d = half_pend_q;
    hi_byte_d   = hi_byte_q;
    push_vld_d  = 1'b0;
    push_word_d = push_word_q;
    if (rx_flag) begin
      if (half_pend_q) begin
        push_vld_d  = 1'b1;
        push_word_d = {hi_byte_q, rx_data};
        half_pend_d = 1'b0;
      end else begin
        hi_byte_d   = rx_data;
        half_pend_d = 1'b1;
      end
    end else if (flush_fire) begin
      half_pend_d = 1'b0;
    end
  end

  // A packed word and a flushed half-word never coincide: the flush needs an idle
  // counter that rx_flag cleared in the cycle before any packed push.
  always_comb begin
    fifo_push      = push_vld_q || (flush_fire && half_pend_q);
    fifo_push_word = push_vld_q ? push_word_q : {hi_byte_q, 8'h00};
    push_ok        = fifo_push && (fill_q != FULL);
    pop            = (state_q == XFER) && wr_en && (pop_cnt_q < n_q);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    if (push_ok)
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push_ok && !pop)
      fill_d = fill_q + CW'(1);
    else if (!push_ok && pop)
      fill_d = fill_q - CW'(1);
    if (fifo_push && (fill_q == FULL))
      overflow_d = 1'b1;
  end

  // Reading at the next read pointer keeps the head word ready the cycle after a pop.
  always_ff @(posedge sys_clk) begin
    if (push_ok)
      mem[wr_ptr_q] <= fifo_push_word;
    rd_word_q <= mem[rd_ptr_d];
  end

  always_comb begin
    state_d       = state_q;
    wr_req_d      = wr_req_q;
    n_d           = n_q;
    pop_cnt_d     = pop_cnt_q;
    word_cnt_d    = word_cnt_q;
    wr_addr_d     = wr_addr_q;
    sector_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_end && ((fill_q >= SEC) || pad_pend_q)) begin
          state_d    = REQ;
          wr_req_d   = 1'b1;
          n_d        = (fill_q >= SEC) ? SEC : fill_q;
          pop_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      REQ: begin
        if (wr_busy) begin
          wr_req_d = 1'b0;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (wr_en) begin
          if (pop)
            pop_cnt_d = pop_cnt_q + CW'(1);
          word_cnt_d = word_cnt_q + CW'(1);
          if (word_cnt_q == SEC_M1)
            state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!wr_busy) begin
          state_d       = DONE;
          sector_done_d = 1'b1;
        end
      end
      DONE: begin
        wr_addr_d = wr_addr_q + 32'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q       <= IDLE;
      half_pend_q   <= 1'b0;
      hi_byte_q     <= 8'h00;
      push_vld_q    <= 1'b0;
      push_word_q   <= 16'h0000;
      tmo_cnt_q     <= 24'd0;
      pad_pend_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      overflow_q    <= 1'b0;
      n_q           <= '0;
      pop_cnt_q     <= '0;
      word_cnt_q    <= '0;
      wr_req_q      <= 1'b0;
      wr_addr_q     <= START_ADDR;
      sector_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      half_pend_q   <= half_pend_d;
      hi_byte_q     <= hi_byte_d;
      push_vld_q    <= push_vld_d;
      push_word_q   <= push_word_d;
      tmo_cnt_q     <= tmo_cnt_d;
      pad_pend_q    <= pad_pend_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      overflow_q    <= overflow_d;
      n_q           <= n_d;
      pop_cnt_q     <= pop_cnt_d;
      word_cnt_q    <= word_cnt_d;
      wr_req_q      <= wr_req_d;
      wr_addr_q     <= wr_addr_d;
      sector_done_q <= sector_done_d;
    end
  end

  // Words past the latched count are served as zero padding.
  always_comb begin
    wr_data = 16'h0000;
    if (((state_q == REQ) || (state_q == XFER) || (state_q == WAIT_DONE)) && (pop_cnt_q < n_q))
      wr_data = rd_word_q;
  end

  assign wr_req      = wr_req_q;
  assign wr_addr     = wr_addr_q;
  assign sector_done = sector_done_q;
  assign overflow    = overflow_q;
  assign fill_level  = fill_q;

endmodule

// File: tb/tb_uart_sector_buf.sv
// Directed bench for uart_sector_buf with a behavioural SD write-controller model.
`timescale 1ns/1ps
module tb_uart_sector_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_end = 1'b0;
  logic        rx_flag = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_busy;
  logic        wr_en;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;
  logic        sector_done;
  logic        overflow;
  logic [9:0]  fill_level;

  always #5 clk = ~clk;

  uart_sector_buf #(
    .SECTOR_WORDS(256), .ADDR_W(9), .START_ADDR(32'd2000), .TIMEOUT_CYC(24'd1000)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst), .init_end(init_end), .rx_flag(rx_flag),
    .rx_data(rx_data), .wr_busy(wr_busy), .wr_en(wr_en), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .sector_done(sector_done),
    .overflow(overflow), .fill_level(fill_level)
  );

  int errors = 0;
  int checks = 0;
  int ctl_gap = 2;
  int cst = 0;
  int gap_cnt = 0;
  int wcnt = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int peak = 0;
  logic [31:0] req_addrs[$];
  logic [15:0] served[$];

  // SD controller model: accept request, stream 256 wr_en pulses, hold busy, release.
  initial begin
    wr_busy = 1'b0;
    wr_en   = 1'b0;
    forever begin
      @(negedge clk);
      wr_en = 1'b0;
      if (rst) begin
        cst = 0;
        wr_busy = 1'b0;
      end else begin
        case (cst)
          0: if (wr_req) begin
               req_cnt++;
               req_addrs.push_back(wr_addr);
               wr_busy = 1'b1;
               gap_cnt = ctl_gap;
               wcnt = 0;
               cst = 1;
             end
          1: if (gap_cnt > 0) gap_cnt--;
             else begin
               served.push_back(wr_data);
               wr_en = 1'b1;
               wcnt++;
               gap_cnt = ctl_gap;
               if (wcnt == 256) begin cst = 2; gap_cnt = 3; end
             end
          default: if (gap_cnt > 0) gap_cnt--;
                   else begin wr_busy = 1'b0; cst = 0; end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sector_done === 1'b1) done_cnt++;
      if (int'(fill_level) > peak) peak = int'(fill_level);
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    rx_flag = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req_cnt = 0;
    done_cnt = 0;
    peak = 0;
    served.delete();
    req_addrs.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_flag = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_flag = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    int n = 0;
    while (done_cnt < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %b expected 0", wr_req); end
    checks++; if (wr_addr !== 32'd2000) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 2000", wr_addr); end
    checks++; if (wr_data !== 16'h0000) begin errors++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data); end
    checks++; if (sector_done !== 1'b0) begin errors++; $display("FAIL reset_sector_done: got %b expected 0", sector_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (fill_level !== 10'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
    $display("reset: outputs checked");
  endtask

  task automatic test_full_sector();
    logic [15:0] exp;
    reset_dut();
    init_end = 1'b1;
    ctl_gap = 2;
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1);
    wait_done(1, 5000);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (req_cnt != 1 || req_addrs.size() != 1 || req_addrs[0] !== 32'd2000) begin
      errors++; $display("FAIL full_req: got count %0d first addr %0d expected 1 at 2000", req_cnt, (req_addrs.size() > 0) ? req_addrs[0] : 32'd0); end
    checks++; if (served.size() != 256) begin errors++; $display("FAIL full_served_size: got %0d expected 256", served.size()); end
    for (int k = 0; k < 256 && k < served.size(); k++) begin
      exp = {8'(2*k), 8'(2*k+1)};
      checks++; if (served[k] !== exp) begin errors++; $display("FAIL full_word[%0d]: got %h expected %h", k, served[k], exp); end
    end
    checks++; if (wr_addr !== 32'd2001) begin errors++; $display("FAIL full_wr_addr: got %0d expected 2001", wr_addr); end
    checks++; if (fill_level !== 10'd0) begin errors++; $display("FAIL full_fill: got %0d expected 0", fill_level); end
    $display("full_sector: req=%0d words=%0d addr=%0d", req_cnt, served.size(), wr_addr);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    reset_dut();
    init_end = 1'b1;
    ctl_gap = 6;
    for (int i = 0; i < 1024; i++) begin
      rx_flag = 1'b1;
      rx_data = 8'(i);
      @(negedge clk);
    end
    rx_flag = 1'b0;
    wait_done(2, 12000);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d expected 2", done_cnt); end
    checks++; if (req_addrs.size() != 2 || req_addrs[0] !== 32'd2000 || req_addrs[1] !== 32'd2001) begin
      errors++; $display("FAIL b2b_addrs: got %0d requests expected 2 at 2000,2001", req_addrs.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    checks++; if (peak > 512 || peak < 256) begin errors++; $display("FAIL b2b_peak: got %0d expected 256..512", peak); end
    checks++; if (served.size() != 512) begin errors++; $display("FAIL b2b_served_size: got %0d expected 512", served.size()); end
    for (int k = 0; k < 512 && k < served.size(); k++) begin
      exp = {8'(2*k), 8'(2*k+1)};
      checks++; if (served[k] !== exp) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", k, served[k], exp); end
    end
    checks++; if (wr_addr !== 32'd2002) begin errors++; $display("FAIL b2b_wr_addr: got %0d expected 2002", wr_addr); end
    $display("back_to_back: sectors=%0d peak=%0d overflow=%b", done_cnt, peak, overflow);
  endtask

  task automatic test_pad();
    int n = 0;
    logic [15:0] exp;
    reset_dut();
    init_end = 1'b1;
    ctl_gap = 2;
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 1);
    checks++; if (fill_level !== 10'd1) begin errors++; $display("FAIL pad_fill_before: got %0d expected 1", fill_level); end
    repeat (900) @(negedge clk);
    checks++; if (wr_req !== 1'b0 || req_cnt != 0) begin errors++; $display("FAIL pad_early_req: got wr_req %b count %0d expected none", wr_req, req_cnt); end
    while (cst != 1 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (cst != 1) begin errors++; $display("FAIL pad_req_timeout: got controller state %0d expected 1", cst); end
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    wait_done(1, 3000);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL pad_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (fill_level !== 10'd1) begin errors++; $display("FAIL pad_fill_after: got %0d expected 1", fill_level); end
    checks++; if (served.size() < 256) begin errors++; $display("FAIL pad_served_size: got %0d expected 256", served.size()); end
    for (int k = 0; k < 256 && k < served.size(); k++) begin
      exp = (k == 0) ? 16'hAABB : (k == 1) ? 16'hCC00 : 16'h0000;
      checks++; if (served[k] !== exp) begin errors++; $display("FAIL pad_word[%0d]: got %h expected %h", k, served[k], exp); end
    end
    wait_done(2, 4000);
    checks++; if (served.size() < 258 || served[256] !== 16'h1122 || served[257] !== 16'h0000) begin
      errors++; $display("FAIL pad_second_sector: got %0d words first %h expected 1122 then 0000", served.size(), (served.size() > 256) ? served[256] : 16'hxxxx); end
    checks++; if (req_addrs.size() != 2 || req_addrs[0] !== 32'd2000 || req_addrs[1] !== 32'd2001) begin
      errors++; $display("FAIL pad_addrs: got %0d requests expected 2 at 2000,2001", req_addrs.size()); end
    $display("pad: first words %h %h, sectors=%0d", (served.size() > 0) ? served[0] : 16'h0, (served.size() > 1) ? served[1] : 16'h0, done_cnt);
  endtask

  task automatic test_no_init();
    reset_dut();
    init_end = 1'b0;
    for (int i = 0; i < 1024; i++) begin rx_flag = 1'b1; rx_data = 8'(i); @(negedge clk); end
    rx_flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fill_level !== 10'd512) begin errors++; $display("FAIL noinit_fill_512: got %0d expected 512", fill_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL noinit_no_overflow_yet: got %b expected 0", overflow); end
    for (int i = 1024; i < 1026; i++) begin rx_flag = 1'b1; rx_data = 8'(i); @(negedge clk); end
    rx_flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL noinit_overflow_513: got %b expected 1", overflow); end
    for (int i = 1026; i < 1100; i++) begin rx_flag = 1'b1; rx_data = 8'(i); @(negedge clk); end
    rx_flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fill_level !== 10'd512) begin errors++; $display("FAIL noinit_fill_end: got %0d expected 512", fill_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL noinit_overflow_sticky: got %b expected 1", overflow); end
    checks++; if (req_cnt != 0 || wr_req !== 1'b0) begin errors++; $display("FAIL noinit_req: got count %0d wr_req %b expected none", req_cnt, wr_req); end
    $display("no_init: fill=%0d overflow=%b requests=%0d", fill_level, overflow, req_cnt);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [15:0] exp;
    reset_dut();
    init_end = 1'b1;
    ctl_gap = 2;
    for (int i = 0; i < 512; i++) begin rx_flag = 1'b1; rx_data = 8'(i*3); @(negedge clk); end
    rx_flag = 1'b0;
    while (served.size() < 10 && n < 5000) begin @(negedge clk); n++; end
    checks++; if (served.size() < 10) begin errors++; $display("FAIL mid_xfer_timeout: got %0d words expected >=10", served.size()); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wr_data !== 16'h0000) begin errors++; $display("FAIL mid_wr_data: got %h expected 0000", wr_data); end
    checks++; if (fill_level !== 10'd0) begin errors++; $display("FAIL mid_fill: got %0d expected 0", fill_level); end
    checks++; if (wr_req !== 1'b0 || sector_done !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL mid_flags: got req %b done %b ovf %b expected 0 0 0", wr_req, sector_done, overflow); end
    checks++; if (wr_addr !== 32'd2000) begin errors++; $display("FAIL mid_wr_addr: got %0d expected 2000", wr_addr); end
    reset_dut();
    for (int i = 0; i < 512; i++) send_byte(8'(255 - i), 1);
    wait_done(1, 5000);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != 1 || req_addrs.size() != 1 || req_addrs[0] !== 32'd2000) begin
      errors++; $display("FAIL mid_resume_req: got %0d sectors %0d requests expected 1 at 2000", done_cnt, req_addrs.size()); end
    checks++; if (served.size() != 256) begin errors++; $display("FAIL mid_served_size: got %0d expected 256", served.size()); end
    for (int k = 0; k < 256 && k < served.size(); k++) begin
      exp = {8'(255 - 2*k), 8'(254 - 2*k)};
      checks++; if (served[k] !== exp) begin errors++; $display("FAIL mid_word[%0d]: got %h expected %h", k, served[k], exp); end
    end
    $display("reset_mid: resumed sectors=%0d addr=%0d", done_cnt, wr_addr);
  endtask

  initial begin
    test_reset();
    test_full_sector();
    test_back_to_back();
    test_pad();
    test_no_init();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
